// File: rtl/imm_enc_pkg.sv
// Shared constants for the immediate encoder: extender op codes and FSM state encoding.
package imm_enc_pkg;

    localparam logic [1:0] EOP_SEXT = 2'b00;
    localparam logic [1:0] EOP_ZEXT = 2'b01;
    localparam logic [1:0] EOP_LUI  = 2'b10;
    localparam logic [1:0] EOP_SHL2 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SINGLE  = 2'b01,
        ST_PAIR_HI = 2'b10,
        ST_PAIR_LO = 2'b11
    } state_t;

endpackage

// File: rtl/imm_classify.sv
// Combinational classifier: picks the cheapest extender op that rebuilds a 32-bit constant,
// or falls back to a LUI + zero-extended ORI pair.
module imm_classify
    import imm_enc_pkg::*;
#(
    parameter int ALLOW_SHL2 = 1
) (
    input  logic [31:0] value,
    output logic        is_pair,
    output logic [1:0]  eop,
    output logic [15:0] imm_hi,
    output logic [15:0] imm_lo
);

    logic sext_ok;
    logic zext_ok;
    logic lui_ok;
    logic shl2_ok;

    assign sext_ok = (&value[31:15]) || (~|value[31:15]);
    assign zext_ok = ~|value[31:16];
    assign lui_ok  = ~|value[15:0];
    assign shl2_ok = (ALLOW_SHL2 != 0) && (~|value[1:0]) &&
                     ((&value[31:17]) || (~|value[31:17]));

    // imm_hi carries the first (or only) beat; imm_lo is only used by the second pair beat.
    always_comb begin
        // NOTE: every output gets a default first so no path through the priority chain infers a latch.
        is_pair = 1'b0;
        eop     = EOP_SEXT;
        imm_hi  = value[15:0];
        imm_lo  = value[15:0];
        if (sext_ok) begin
            eop = EOP_SEXT;
        end else if (zext_ok) begin
            eop = EOP_ZEXT;
        end else if (lui_ok) begin
            eop    = EOP_LUI;
            imm_hi = value[31:16];
        end else if (shl2_ok) begin
            eop    = EOP_SHL2;
            imm_hi = value[17:2];
        end else begin
            is_pair = 1'b1;
            eop     = EOP_LUI;
            imm_hi  = value[31:16];
        end
    end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder top: handshaked FSM emitting one or two {imm, eop} beats per constant.
// Define IMM_ENC_STATS_EN to add saturating single/pair hand-off counters.
module imm_encoder
    import imm_enc_pkg::*;
#(
    parameter int ALLOW_SHL2 = 1
`ifdef IMM_ENC_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_imm,
    output logic [1:0]  out_eop,
    output logic        out_last,
    output logic        out_pair
`ifdef IMM_ENC_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_single,
    output logic [CNT_W-1:0] stat_pair
`endif
);

    state_t      state;
    logic [15:0] lo_imm;
    logic        cls_pair;
    logic [1:0]  cls_eop;
    logic [15:0] cls_hi;
    logic [15:0] cls_lo;
    logic        accept;
    logic        handoff;
    logic        last_handoff;

    imm_classify #(.ALLOW_SHL2(ALLOW_SHL2)) u_classify (
        .value   (in_value),
        .is_pair (cls_pair),
        .eop     (cls_eop),
        .imm_hi  (cls_hi),
        .imm_lo  (cls_lo)
    );

    assign handoff      = out_valid && out_ready;
    assign last_handoff = handoff && out_last;
    assign in_ready     = (state == ST_IDLE) || last_handoff;
    assign accept       = in_valid && in_ready;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_imm   <= 16'h0000;
            out_eop   <= EOP_SEXT;
            out_last  <= 1'b0;
            out_pair  <= 1'b0;
            lo_imm    <= 16'h0000;
        end else if (accept) begin
            // Loading on the last hand-off gives back-to-back constants without a bubble.
            out_valid <= 1'b1;
            out_imm   <= cls_hi;
            lo_imm    <= cls_lo;
            if (cls_pair) begin
                state    <= ST_PAIR_HI;
                out_eop  <= EOP_LUI;
                out_last <= 1'b0;
                out_pair <= 1'b1;
            end else begin
                state    <= ST_SINGLE;
                out_eop  <= cls_eop;
                out_last <= 1'b1;
                out_pair <= 1'b0;
            end
        end else if (handoff) begin
            case (state)
                ST_PAIR_HI: begin
                    state    <= ST_PAIR_LO;
                    out_imm  <= lo_imm;
                    out_eop  <= EOP_ZEXT;
                    out_last <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef IMM_ENC_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_single <= '0;
            stat_pair   <= '0;
        end else if (last_handoff) begin
            if (out_pair) begin
                if (!(&stat_pair)) stat_pair <= stat_pair + 1'b1;
            end else begin
                if (!(&stat_single)) stat_single <= stat_single + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Directed self-checking bench for imm_encoder; a second instance covers ALLOW_SHL2=0.
// Honours IMM_ENC_STATS_EN when the design is built with it.
module tb_imm_encoder;

    logic        clk;
    logic        reset;
    logic        in_valid, in_valid0;
    logic        in_ready, in_ready0;
    logic [31:0] in_value, in_value0;
    logic        out_valid, out_valid0;
    logic        out_ready, out_ready0;
    logic [15:0] out_imm, out_imm0;
    logic [1:0]  out_eop, out_eop0;
    logic        out_last, out_last0;
    logic        out_pair, out_pair0;
`ifdef IMM_ENC_STATS_EN
    logic [15:0] stat_single, stat_single0;
    logic [15:0] stat_pair, stat_pair0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    imm_encoder #(.ALLOW_SHL2(1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_eop(out_eop), .out_last(out_last), .out_pair(out_pair)
`ifdef IMM_ENC_STATS_EN
        , .stat_single(stat_single), .stat_pair(stat_pair)
`endif
    );

    imm_encoder #(.ALLOW_SHL2(0)) dut0 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_value(in_value0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_imm(out_imm0),
        .out_eop(out_eop0), .out_last(out_last0), .out_pair(out_pair0)
`ifdef IMM_ENC_STATS_EN
        , .stat_single(stat_single0), .stat_pair(stat_pair0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, where outputs are stable.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input string tag, input logic [1:0] eop, input logic [15:0] imm,
                              input logic last, input logic pair);
        check({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, ".eop"},   {30'b0, out_eop},   {30'b0, eop});
        check({tag, ".imm"},   {16'b0, out_imm},   {16'b0, imm});
        check({tag, ".last"},  {31'b0, out_last},  {31'b0, last});
        check({tag, ".pair"},  {31'b0, out_pair},  {31'b0, pair});
    endtask

    typedef struct {
        logic [31:0] value;
        logic [1:0]  eop;
        logic [15:0] imm;
    } single_vec_t;

    single_vec_t singles [7] = '{
        '{32'hFFFF_8000, 2'b00, 16'h8000},
        '{32'h0000_ABCD, 2'b01, 16'hABCD},
        '{32'h1234_0000, 2'b10, 16'h1234},
        '{32'h0001_FFFC, 2'b11, 16'h7FFF},
        '{32'h0000_0000, 2'b00, 16'h0000},
        '{32'hFFFF_FFFF, 2'b00, 16'hFFFF},
        '{32'h0000_8000, 2'b01, 16'h8000}
    };

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;  in_value  = 32'h0;  out_ready  = 1'b0;
        in_valid0  = 1'b0;  in_value0 = 32'h0;  out_ready0 = 1'b0;
        step();
        step();
        check("rst.valid", {31'b0, out_valid}, 32'd0);
        check("rst.imm",   {16'b0, out_imm},   32'd0);
        check("rst.eop",   {30'b0, out_eop},   32'd0);
        check("rst.last",  {31'b0, out_last},  32'd0);
        check("rst.pair",  {31'b0, out_pair},  32'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
        check("rst.in_ready", {31'b0, in_ready}, 32'd1);

        // Single-beat classifications, including the boundary constants.
        foreach (singles[i]) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_value  = singles[i].value;
            out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            check_beat($sformatf("single%0d", i), singles[i].eop, singles[i].imm, 1'b1, 1'b0);
            step();
            check($sformatf("single%0d.idle", i), {31'b0, out_valid}, 32'd0);
        end

        // Without SHL2 the same constant needs a LUI/ORI pair.
        @(negedge clk);
        in_valid0  = 1'b1;
        in_value0  = 32'h0001_FFFC;
        out_ready0 = 1'b1;
        step();
        in_valid0 = 1'b0;
        check("noshl2.hi.eop",  {30'b0, out_eop0},  32'h2);
        check("noshl2.hi.imm",  {16'b0, out_imm0},  32'h0001);
        check("noshl2.hi.last", {31'b0, out_last0}, 32'd0);
        step();
        check("noshl2.lo.eop",  {30'b0, out_eop0},  32'h1);
        check("noshl2.lo.imm",  {16'b0, out_imm0},  32'hFFFC);
        check("noshl2.lo.last", {31'b0, out_last0}, 32'd1);
        check("noshl2.lo.pair", {31'b0, out_pair0}, 32'd1);
        step();
        check("noshl2.idle", {31'b0, out_valid0}, 32'd0);

        // Pair under back-pressure; in_value changes after accept to prove the low half is latched.
        @(negedge clk);
        in_valid  = 1'b1;
        in_value  = 32'h1234_5678;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        in_value = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            check_beat($sformatf("stall%0d", k), 2'b10, 16'h1234, 1'b0, 1'b1);
            check($sformatf("stall%0d.in_ready", k), {31'b0, in_ready}, 32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        check_beat("stall.lo", 2'b01, 16'h5678, 1'b1, 1'b1);
        step();
        check("stall.idle", {31'b0, out_valid}, 32'd0);

        // Back-to-back singles: one result per cycle.
        @(negedge clk);
        in_valid = 1'b1;
        in_value = 32'h1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check_beat($sformatf("b2b%0d", k), 2'b00, 16'(k), 1'b1, 1'b0);
            check($sformatf("b2b%0d.in_ready", k), {31'b0, in_ready}, 32'd1);
            if (k < 3) in_value = 32'(k + 1);
            else       in_valid = 1'b0;
        end
        step();
        check("b2b.idle", {31'b0, out_valid}, 32'd0);

        // Reset while the high beat of a pair is pending.
        @(negedge clk);
        in_valid  = 1'b1;
        in_value  = 32'h1234_5678;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check_beat("prerst", 2'b10, 16'h1234, 1'b0, 1'b1);
        reset = 1'b0;
        step();
        check("midrst.valid",    {31'b0, out_valid}, 32'd0);
        check("midrst.in_ready", {31'b0, in_ready},  32'd1);
`ifdef IMM_ENC_STATS_EN
        check("midrst.stat_pair", {16'b0, stat_pair}, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;

        // Three pairs back to back: two cycles per constant.
        in_valid  = 1'b1;
        in_value  = 32'h1234_5678;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_beat($sformatf("pairs%0d.hi", k), 2'b10, 16'h1234, 1'b0, 1'b1);
            if (k == 2) in_valid = 1'b0;
            step();
            check_beat($sformatf("pairs%0d.lo", k), 2'b01, 16'h5678, 1'b1, 1'b1);
        end
        step();
        check("pairs.idle", {31'b0, out_valid}, 32'd0);
`ifdef IMM_ENC_STATS_EN
        check("stats.pair",   {16'b0, stat_pair},   32'd3);
        check("stats.single", {16'b0, stat_single}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
